// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
// Round-robin controller sharing one external 16-bit divider between
// N_REQ = 2**ID_W requesters. It arbitrates level requests, latches the
// winner's operands, sequences the divider init/done handshake and returns
// the 32-bit result with a one-cycle one-hot acknowledge.
//
// Parameters
//   ID_W      requester index width (N_REQ = 2**ID_W)
//   INIT_LEN  cycles div_init is held high per operation (>= 1)
//   TIMEOUT   watchdog limit in WAIT cycles (only with DIV_ARB_WDT_EN)
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req               per-requester level request
//   op_A_bus/op_B_bus packed dividends/divisors, requester i at [16i+15:16i]
//   ack               one-hot pulse marking result/err valid
//   result, err       last completed result, watchdog abort flag
//   busy, grant_id    not-idle flag, current/last granted requester
//   div_init          start pulse to the divider
//   div_op_A/div_op_B latched operands to the divider
//   div_result        divider result
//   div_done          divider completion level
//
// Build option
//   DIV_ARB_WDT_EN    enables the WAIT watchdog; otherwise err is tied low
//                     and WAIT lasts until div_done.
// ---------------------------------------------------------------------------
module div_arbiter #(
    parameter int unsigned ID_W     = 2,
    parameter int unsigned INIT_LEN = 2,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [(2**ID_W)-1:0]     req,
    input  logic [16*(2**ID_W)-1:0]  op_A_bus,
    input  logic [16*(2**ID_W)-1:0]  op_B_bus,
    output logic [(2**ID_W)-1:0]     ack,
    output logic [31:0]              result,
    output logic                     err,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id,
    output logic                     div_init,
    output logic [15:0]              div_op_A,
    output logic [15:0]              div_op_B,
    input  logic [31:0]              div_result,
    input  logic                     div_done
);

    localparam int unsigned N_REQ  = 2 ** ID_W;
    localparam int unsigned INIT_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RETIRE = 2'd3;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [INIT_W-1:0] init_cnt;
    logic [INIT_W-1:0] init_cnt_d;

    logic              busy_d;
    logic              init_d;
    logic [N_REQ-1:0]  ack_d;
    logic [31:0]       result_d;
    logic [ID_W-1:0]   grant_d;
    logic [15:0]       op_a_d;
    logic [15:0]       op_b_d;

`ifdef DIV_ARB_WDT_EN
    localparam int unsigned WDT_W = $clog2(TIMEOUT + 1);

    logic [WDT_W-1:0]  wdt_cnt;
    logic [WDT_W-1:0]  wdt_cnt_d;
    logic              err_q;
    logic              err_d;
`endif

    // Round-robin search: start one past the last winner, wrap back to it.
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        win   = grant_id;
        cand  = grant_id;
        found = 1'b0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand = grant_id + ID_W'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every output is a flop fed from here.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt;
        busy_d     = busy;
        init_d     = 1'b0;
        ack_d      = '0;
        result_d   = result;
        grant_d    = grant_id;
        op_a_d     = div_op_A;
        op_b_d     = div_op_B;
`ifdef DIV_ARB_WDT_EN
        wdt_cnt_d  = wdt_cnt;
        err_d      = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_ISSUE;
                    busy_d     = 1'b1;
                    init_d     = 1'b1;
                    init_cnt_d = '0;
                    grant_d    = win;
                    op_a_d     = op_A_bus[16*win +: 16];
                    op_b_d     = op_B_bus[16*win +: 16];
`ifdef DIV_ARB_WDT_EN
                    wdt_cnt_d  = '0;
`endif
                end
            end

            S_ISSUE: begin
                // div_init was raised on entry; hold it INIT_LEN cycles total.
                if (init_cnt == INIT_W'(INIT_LEN - 1)) begin
                    state_d = S_WAIT;
                end else begin
                    init_d     = 1'b1;
                    init_cnt_d = init_cnt + INIT_W'(1);
                end
            end

            S_WAIT: begin
                if (div_done) begin
                    state_d  = S_RETIRE;
                    ack_d    = N_REQ'(1) << grant_id;
                    result_d = div_result;
`ifdef DIV_ARB_WDT_EN
                    err_d    = 1'b0;
                end else if (wdt_cnt == WDT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th WAIT cycle without done: abort.
                    state_d  = S_RETIRE;
                    ack_d    = N_REQ'(1) << grant_id;
                    result_d = 32'hFFFF_FFFF;
                    err_d    = 1'b1;
                end else begin
                    wdt_cnt_d = wdt_cnt + WDT_W'(1);
`endif
                end
            end

            S_RETIRE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            init_cnt <= '0;
            busy     <= 1'b0;
            div_init <= 1'b0;
            ack      <= '0;
            result   <= '0;
            grant_id <= ID_W'(N_REQ - 1);
            div_op_A <= '0;
            div_op_B <= '0;
        end else begin
            state_q  <= state_d;
            init_cnt <= init_cnt_d;
            busy     <= busy_d;
            div_init <= init_d;
            ack      <= ack_d;
            result   <= result_d;
            grant_id <= grant_d;
            div_op_A <= op_a_d;
            div_op_B <= op_b_d;
        end
    end

`ifdef DIV_ARB_WDT_EN
    // Watchdog counter and abort flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            wdt_cnt <= wdt_cnt_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_arbiter
// Directed bench for div_arbiter with a divider stub: done rises 17 cycles
// after init falls, result = {op_B, op_A}. Covers reset values, basic timing,
// round-robin order, fairness with a repeat requester, operand freeze,
// reset mid-operation and the watchdog (behaviour depends on DIV_ARB_WDT_EN).
// ---------------------------------------------------------------------------
module tb_div_arbiter;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [3:0]  req      = '0;
    logic [63:0] op_A_bus = '0;
    logic [63:0] op_B_bus = '0;
    logic [3:0]  ack;
    logic [31:0] result;
    logic        err;
    logic        busy;
    logic [1:0]  grant_id;
    logic        div_init;
    logic [15:0] div_op_A;
    logic [15:0] div_op_B;
    logic [31:0] div_result;
    logic        div_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    div_arbiter #(.ID_W(2), .INIT_LEN(2), .TIMEOUT(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .op_A_bus   (op_A_bus),
        .op_B_bus   (op_B_bus),
        .ack        (ack),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .grant_id   (grant_id),
        .div_init   (div_init),
        .div_op_A   (div_op_A),
        .div_op_B   (div_op_B),
        .div_result (div_result),
        .div_done   (div_done)
    );

    always #5 clk = ~clk;

    // Divider stub.
    logic stub_hang = 1'b0;
    logic stub_arm  = 1'b0;
    int   stub_cnt  = 0;

    assign div_result = {div_op_B, div_op_A};

    always @(posedge clk) begin
        if (div_init) begin
            stub_cnt <= 0;
            div_done <= 1'b0;
            stub_arm <= 1'b1;
        end else if (stub_arm && !stub_hang) begin
            if (stub_cnt == 16) begin
                div_done <= 1'b1;
                stub_arm <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until ack is seen or the cycle budget runs out.
    task automatic wait_ack(input int limit, output int n, output logic seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            tick();
            n++;
            if (ack != 4'b0000) seen = 1'b1;
        end
    endtask

    task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b);
        op_A_bus[16*id +: 16] = a;
        op_B_bus[16*id +: 16] = b;
    endtask

    // Global time guard.
    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench timeout");
    end

    logic [15:0] rr_a   [4] = '{16'hA000, 16'hA101, 16'hA202, 16'hA303};
    logic [15:0] rr_b   [4] = '{16'h0B00, 16'h0B11, 16'h0B22, 16'h0B33};
    logic [31:0] rr_res [4] = '{32'h0B00_A000, 32'h0B11_A101, 32'h0B22_A202, 32'h0B33_A303};
    int          fair_id[3] = '{2, 3, 2};
    logic [31:0] fair_res[3] = '{32'h0B22_A202, 32'h0B33_A303, 32'h0B22_A202};

    initial begin
        int   n;
        logic seen;
        logic [3:0] exp_ack;

        // Reset values.
        reset = 1'b1;
        tick();
        tick();
        check("rst_ack",      32'(ack),      32'h0);
        check("rst_result",   result,        32'h0);
        check("rst_err",      32'(err),      32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_grant",    32'(grant_id), 32'h3);
        check("rst_init",     32'(div_init), 32'h0);
        check("rst_op_a",     32'(div_op_A), 32'h0);
        check("rst_op_b",     32'(div_op_B), 32'h0);
        reset = 1'b0;
        tick();

        // Single request, basic timing.
        set_ops(0, 16'hC86C, 16'h00CA);
        req = 4'b0001;
        tick();
        check("t1_busy_k1",   32'(busy),     32'h1);
        check("t1_init_k1",   32'(div_init), 32'h1);
        check("t1_grant",     32'(grant_id), 32'h0);
        check("t1_op_a",      32'(div_op_A), 32'h0000_C86C);
        check("t1_op_b",      32'(div_op_B), 32'h0000_00CA);
        tick();
        check("t1_init_k2",   32'(div_init), 32'h1);
        tick();
        check("t1_init_k3",   32'(div_init), 32'h0);
        check("t1_busy_k3",   32'(busy),     32'h1);
        wait_ack(100, n, seen);
        check("t1_seen",      32'(seen),     32'h1);
        check("t1_latency",   32'(n),        32'd18);
        check("t1_ack",       32'(ack),      32'h1);
        check("t1_result",    result,        32'h00CA_C86C);
        check("t1_err",       32'(err),      32'h0);
        req = 4'b0000;
        tick();
        check("t1_ack_clr",   32'(ack),      32'h0);
        check("t1_busy_idle", 32'(busy),     32'h0);
        check("t1_res_hold",  result,        32'h00CA_C86C);

        // Operand freeze during WAIT.
        req = 4'b0001;
        tick();
        tick();
        tick();
        set_ops(0, 16'h1234, 16'h00CA);
        wait_ack(100, n, seen);
        check("frz_seen",     32'(seen),     32'h1);
        check("frz_result",   result,        32'h00CA_C86C);
        req = 4'b0000;
        tick();

        // Round-robin order after reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_ops(i, rr_a[i], rr_b[i]);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_ack = 4'b0001 << k;
            wait_ack(100, n, seen);
            check("rr_seen",   32'(seen),     32'h1);
            check("rr_ack",    32'(ack),      32'(exp_ack));
            check("rr_grant",  32'(grant_id), 32'(k));
            check("rr_result", result,        rr_res[k]);
            req = req & ~ack;
        end

        // Fairness: requester 2 re-asserts right after its ack.
        req = 4'b1100;
        for (int j = 0; j < 3; j++) begin
            exp_ack = 4'b0001 << fair_id[j];
            wait_ack(100, n, seen);
            check("fair_seen",   32'(seen),  32'h1);
            check("fair_ack",    32'(ack),   32'(exp_ack));
            check("fair_result", result,     fair_res[j]);
            req = req & ~ack;
            if (j == 0) begin
                tick();
                req[2] = 1'b1;
            end
        end
        tick();

        // Reset in the middle of WAIT.
        set_ops(0, 16'hC86C, 16'h00CA);
        req = 4'b0001;
        for (int i = 0; i < 6; i++) tick();
        check("mid_busy_pre", 32'(busy),     32'h1);
        reset = 1'b1;
        tick();
        check("mid_busy",     32'(busy),     32'h0);
        check("mid_init",     32'(div_init), 32'h0);
        check("mid_ack",      32'(ack),      32'h0);
        check("mid_grant",    32'(grant_id), 32'h3);
        reset = 1'b0;
        set_ops(0, 16'h0042, 16'h0007);
        wait_ack(100, n, seen);
        check("mid_seen",     32'(seen),     32'h1);
        check("mid_ack2",     32'(ack),      32'h1);
        check("mid_result",   result,        32'h0007_0042);
        check("mid_err",      32'(err),      32'h0);
        req = 4'b0000;
        tick();

        // Watchdog: divider never completes.
        stub_hang = 1'b1;
        req = 4'b0001;
        tick();
        check("wdt_busy",     32'(busy),     32'h1);
        wait_ack(150, n, seen);
`ifdef DIV_ARB_WDT_EN
        check("wdt_seen",     32'(seen),     32'h1);
        check("wdt_latency",  32'(n),        32'd66);
        check("wdt_ack",      32'(ack),      32'h1);
        check("wdt_result",   result,        32'hFFFF_FFFF);
        check("wdt_err",      32'(err),      32'h1);
`else
        check("wdt_noack",    32'(seen),     32'h0);
        check("wdt_stuck",    32'(busy),     32'h1);
        check("wdt_err_tie",  32'(err),      32'h0);
`endif
        req = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stub_hang = 1'b0;
        tick();
        check("end_busy",     32'(busy),     32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
